id_ex_elastic: RTL and testbench

ID_EX_ELASTIC -- requirements
Module: id_ex_elastic

---
 rtl/id_ex_elastic.sv | 131 +++++++++++++
 tb/tb_id_ex_elastic.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_elastic.sv
// ID/EX pipeline register with valid/ready handshaking and an optional skid entry.
// The main entry drives EX; the skid entry absorbs one extra instruction so in_ready can be registered.
module id_ex_elastic #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [7:0]        CtrlSig,
    input  logic [DATA_W-1:0] data1in,
    input  logic [DATA_W-1:0] data2in,
    input  logic [DATA_W-1:0] extendedin,
    input  logic [REG_W-1:0]  rs_ID,
    input  logic [REG_W-1:0]  rt_ID,
    input  logic [REG_W-1:0]  rd_ID,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        WBSig,
    output logic [1:0]        MSig,
    output logic              RegDst,
    output logic [1:0]        ALUOp,
    output logic              ALUSrc,
    output logic [DATA_W-1:0] data1out,
    output logic [DATA_W-1:0] data2out,
    output logic [DATA_W-1:0] extendedout,
    output logic [REG_W-1:0]  rs_EX,
    output logic [REG_W-1:0]  rt_EX,
    output logic [REG_W-1:0]  rd_EX,
    output logic [1:0]        occupancy
);

    localparam bit HAS_SKID = (SKID_EN != 0);

    typedef struct packed {
        logic [7:0]        ctrl;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [DATA_W-1:0] ext;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } entry_t;

    entry_t     m_q, m_n, s_q, s_n, in_e;
    logic       m_valid, m_valid_n;
    logic       s_valid, s_valid_n;
    logic       accept, retire;
    logic [1:0] occ_q;

    // Without a skid entry the stage can only accept when M is empty or draining this cycle.
    generate
        if (HAS_SKID) begin : g_skid_ready
            assign in_ready = !s_valid;
        end else begin : g_direct_ready
            assign in_ready = !m_valid || out_ready;
        end
    endgenerate

    assign accept = in_valid && in_ready;
    assign retire = m_valid && out_ready;

    assign in_e = '{ctrl: CtrlSig, d1: data1in, d2: data2in, ext: extendedin,
                    rs: rs_ID, rt: rt_ID, rd: rd_ID};

    // Next-state: M refills from S first so order is kept; S takes the input only when M stays occupied.
    always_comb begin
        m_n       = m_q;
        s_n       = s_q;
        m_valid_n = m_valid;
        s_valid_n = s_valid;
        if (flush) begin
            m_valid_n = 1'b0;
            s_valid_n = 1'b0;
        end else if (!m_valid || retire) begin
            if (s_valid) begin
                m_n       = s_q;
                m_valid_n = 1'b1;
                if (accept) begin
                    s_n       = in_e;
                    s_valid_n = 1'b1;
                end else begin
                    s_valid_n = 1'b0;
                end
            end else if (accept) begin
                m_n       = in_e;
                m_valid_n = 1'b1;
            end else begin
                m_valid_n = 1'b0;
            end
        end else if (HAS_SKID && accept) begin
            s_n       = in_e;
            s_valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q     <= '0;
            s_q     <= '0;
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            m_q     <= m_n;
            s_q     <= s_n;
            m_valid <= m_valid_n;
            s_valid <= s_valid_n;
            occ_q   <= {1'b0, m_valid_n} + {1'b0, s_valid_n};
        end
    end

    // Control fields become a bubble whenever nothing valid is presented; data keeps its last value.
    assign out_valid   = m_valid;
    assign WBSig       = m_valid ? m_q.ctrl[7:6] : 2'b00;
    assign MSig        = m_valid ? m_q.ctrl[5:4] : 2'b00;
    assign RegDst      = m_valid ? m_q.ctrl[3]   : 1'b0;
    assign ALUOp       = m_valid ? m_q.ctrl[2:1] : 2'b00;
    assign ALUSrc      = m_valid ? m_q.ctrl[0]   : 1'b0;
    assign data1out    = m_q.d1;
    assign data2out    = m_q.d2;
    assign extendedout = m_q.ext;
    assign rs_EX       = m_q.rs;
    assign rt_EX       = m_q.rt;
    assign rd_EX       = m_q.rd;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_id_ex_elastic.sv
// Bench for id_ex_elastic: a skid instance and a no-skid instance share stimulus,
// each checked against a queue model of a bounded FIFO with the matching ready rule.
module tb_id_ex_elastic;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } tb_entry_t;

    logic        clk;
    logic        reset, in_valid, flush, out_ready;
    logic [7:0]  CtrlSig;
    logic [31:0] data1in, data2in, extendedin;
    logic [4:0]  rs_ID, rt_ID, rd_ID;

    logic        ov[2], ir[2], rdst[2], asrc[2];
    logic [1:0]  wb[2], ms[2], alo[2], occ[2];
    logic [31:0] d1o[2], d2o[2], exo[2];
    logic [4:0]  rso[2], rto[2], rdo[2];

    tb_entry_t   mq[2][2];
    int          mcnt[2];
    tb_entry_t   mlast[2];

    int          nChecks = 0;
    int          nFails  = 0;

    id_ex_elastic #(.DATA_W(32), .REG_W(5), .SKID_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .flush(flush),
        .CtrlSig(CtrlSig), .data1in(data1in), .data2in(data2in), .extendedin(extendedin),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .rd_ID(rd_ID),
        .out_valid(ov[0]), .out_ready(out_ready), .WBSig(wb[0]), .MSig(ms[0]),
        .RegDst(rdst[0]), .ALUOp(alo[0]), .ALUSrc(asrc[0]),
        .data1out(d1o[0]), .data2out(d2o[0]), .extendedout(exo[0]),
        .rs_EX(rso[0]), .rt_EX(rto[0]), .rd_EX(rdo[0]), .occupancy(occ[0])
    );

    id_ex_elastic #(.DATA_W(32), .REG_W(5), .SKID_EN(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .flush(flush),
        .CtrlSig(CtrlSig), .data1in(data1in), .data2in(data2in), .extendedin(extendedin),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .rd_ID(rd_ID),
        .out_valid(ov[1]), .out_ready(out_ready), .WBSig(wb[1]), .MSig(ms[1]),
        .RegDst(rdst[1]), .ALUOp(alo[1]), .ALUSrc(asrc[1]),
        .data1out(d1o[1]), .data2out(d2o[1]), .extendedout(exo[1]),
        .rs_EX(rso[1]), .rt_EX(rto[1]), .rd_EX(rdo[1]), .occupancy(occ[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instance 0 is a 2-deep FIFO (ready while not full); instance 1 is 1-deep with pass-through ready.
    function automatic bit modelReady(input int k);
        if (k == 0) return mcnt[0] < 2;
        return (mcnt[1] == 0) || out_ready;
    endfunction

    task automatic modelUpdate(input bit iv, input bit ordy, input bit fl, input bit rst, input tb_entry_t e);
        bit rdy[2];
        for (int k = 0; k < 2; k++) rdy[k] = modelReady(k);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mcnt[k]  = 0;
                mlast[k] = '0;
            end else if (fl) begin
                mcnt[k] = 0;
            end else begin
                if (ordy && mcnt[k] > 0) begin
                    mq[k][0] = mq[k][1];
                    mcnt[k]--;
                end
                if (iv && rdy[k]) begin
                    mq[k][mcnt[k]] = e;
                    mcnt[k]++;
                end
                if (mcnt[k] > 0) mlast[k] = mq[k][0];
            end
        end
    endtask

    task automatic checkOutput();
        tb_entry_t f;
        bit        v;
        string     p;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? "skid" : "noskid";
            v = mcnt[k] > 0;
            f = v ? mq[k][0] : '0;
            checkEq({p, " out_valid"}, 64'(ov[k]), 64'(v));
            checkEq({p, " in_ready"}, 64'(ir[k]), 64'(modelReady(k)));
            checkEq({p, " WBSig"}, 64'(wb[k]), 64'(f.ctrl[7:6]));
            checkEq({p, " MSig"}, 64'(ms[k]), 64'(f.ctrl[5:4]));
            checkEq({p, " RegDst"}, 64'(rdst[k]), 64'(f.ctrl[3]));
            checkEq({p, " ALUOp"}, 64'(alo[k]), 64'(f.ctrl[2:1]));
            checkEq({p, " ALUSrc"}, 64'(asrc[k]), 64'(f.ctrl[0]));
            checkEq({p, " data1out"}, 64'(d1o[k]), 64'(mlast[k].d1));
            checkEq({p, " data2out"}, 64'(d2o[k]), 64'(mlast[k].d2));
            checkEq({p, " extendedout"}, 64'(exo[k]), 64'(mlast[k].ext));
            checkEq({p, " rs_EX"}, 64'(rso[k]), 64'(mlast[k].rs));
            checkEq({p, " rt_EX"}, 64'(rto[k]), 64'(mlast[k].rt));
            checkEq({p, " rd_EX"}, 64'(rdo[k]), 64'(mlast[k].rd));
            checkEq({p, " occupancy"}, 64'(occ[k]), 64'(mcnt[k]));
        end
    endtask

    // One cycle: drive inputs, compare the pre-edge view with the model, clock, advance the model.
    task automatic applyStimulus(input bit iv, input bit ordy, input bit fl, input bit rst, input tb_entry_t e);
        in_valid   = iv;
        out_ready  = ordy;
        flush      = fl;
        reset      = rst;
        CtrlSig    = e.ctrl;
        data1in    = e.d1;
        data2in    = e.d2;
        extendedin = e.ext;
        rs_ID      = e.rs;
        rt_ID      = e.rt;
        rd_ID      = e.rd;
        #1;
        checkOutput();
        @(posedge clk);
        modelUpdate(iv, ordy, fl, rst, e);
        #1;
    endtask

    function automatic tb_entry_t randEntry();
        tb_entry_t e;
        e.ctrl = 8'($urandom);
        e.d1   = $urandom;
        e.d2   = $urandom;
        e.ext  = $urandom;
        e.rs   = 5'($urandom);
        e.rt   = 5'($urandom);
        e.rd   = 5'($urandom);
        return e;
    endfunction

    initial begin
        tb_entry_t e;
        tb_entry_t idle;
        int        sent;
        int        got;
        bit        ordy;

        idle = '0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        CtrlSig = '0; data1in = '0; data2in = '0; extendedin = '0;
        rs_ID = '0; rt_ID = '0; rd_ID = '0;
        @(posedge clk);
        @(posedge clk);
        modelUpdate(1'b0, 1'b0, 1'b0, 1'b1, idle);
        #1;
        $display("[TB] reset released");

        // Single instruction through an empty stage.
        e = randEntry();
        e.ctrl = 8'hA5;
        e.d1   = 32'h1234;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, e);
        checkEq("req23 out_valid", 64'(ov[0]), 64'd1);
        checkEq("req23 WBSig", 64'(wb[0]), 64'b10);
        checkEq("req23 MSig", 64'(ms[0]), 64'b10);
        checkEq("req23 RegDst", 64'(rdst[0]), 64'd0);
        checkEq("req23 ALUOp", 64'(alo[0]), 64'b10);
        checkEq("req23 ALUSrc", 64'(asrc[0]), 64'd1);
        checkEq("req23 data1out", 64'(d1o[0]), 64'h1234);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle);
        checkEq("req23 bubble valid", 64'(ov[0]), 64'd0);
        checkEq("req23 bubble WBSig", 64'(wb[0]), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle);

        // Back-to-back rd=1,2,3 with EX stalled, then released.
        for (int i = 1; i <= 3; i++) begin
            e = randEntry();
            e.rd = 5'(i);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
        end
        checkEq("req24 occupancy", 64'(occ[0]), 64'd2);
        checkEq("req24 in_ready", 64'(ir[0]), 64'd0);
        checkEq("req24 head rd", 64'(rdo[0]), 64'd1);
        checkEq("req28 noskid in_ready", 64'(ir[1]), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, e);
        for (int i = 0; i < 4; i++) applyStimulus(i == 0, 1'b1, 1'b0, 1'b0, e);

        // Flush while full with an input offered.
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, randEntry());
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, randEntry());
        checkEq("req25 out_valid", 64'(ov[0]), 64'd0);
        checkEq("req25 occupancy", 64'(occ[0]), 64'd0);
        checkEq("req25 in_ready", 64'(ir[0]), 64'd1);
        checkEq("req25 WBSig", 64'(wb[0]), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle);

        // Streaming 20 sequential rs values with out_ready toggling.
        sent = 0;
        got  = 0;
        e    = randEntry();
        for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
            ordy = (cyc % 2) == 0;
            if (ov[0] && ordy) begin
                checkEq("req26 stream order", 64'(rso[0]), 64'(got + 1));
                got++;
            end
            e.rs = 5'(sent + 1);
            if (sent < 20 && modelReady(0)) begin
                applyStimulus(1'b1, ordy, 1'b0, 1'b0, e);
                sent++;
            end else begin
                applyStimulus(sent < 20, ordy, 1'b0, 1'b0, e);
            end
        end
        checkEq("req26 stream count", 64'(got), 64'd20);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle);

        // Reset and flush together while full.
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, randEntry());
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, randEntry());
        checkEq("req27 out_valid", 64'(ov[0]), 64'd0);
        checkEq("req27 data1out", 64'(d1o[0]), 64'd0);
        checkEq("req27 rd_EX", 64'(rdo[0]), 64'd0);
        checkEq("req27 occupancy", 64'(occ[0]), 64'd0);

        // No-skid instance: retire and accept in the same cycle keeps occupancy at 1.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, randEntry());
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, randEntry());
        checkEq("req28 noskid occupancy", 64'(occ[1]), 64'd1);
        checkEq("req28 noskid out_valid", 64'(ov[1]), 64'd1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 29) == 0), ($urandom_range(0, 79) == 0),
                          randEntry());
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idle);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
